// File: rtl/rng_pkg.sv
// Shared constants, FSM state type and LFSR step function for bounded_rng.
package rng_pkg;

  localparam int unsigned LFSR_BITS = 16;
  localparam logic [LFSR_BITS-1:0] LFSR_MASK    = 16'hB400;
  localparam logic [LFSR_BITS-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [LFSR_BITS-1:0] lfsr_step(input logic [LFSR_BITS-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : {LFSR_BITS{1'b0}});
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a load takes priority over the advance.
module lfsr16
  import rng_pkg::*;
#(
  parameter logic [LFSR_BITS-1:0] SEED = DEFAULT_SEED
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [LFSR_BITS-1:0] load_val,
  output logic [LFSR_BITS-1:0] q
);

  // A zero load value would lock the register up, so it maps to SEED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (load) begin
      q <= (load_val != '0) ? load_val : SEED;
    end else begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/bounded_rng.sv
// Draws a value in [0, MAX_VALUE] from a free-running LFSR, optionally never
// repeating the previous value, with a deterministic fallback after MAX_TRIES.
module bounded_rng
  import rng_pkg::*;
#(
  parameter int unsigned          WIDTH     = 4,
  parameter int                   MAX_VALUE = 15,
  parameter int                   NO_REPEAT = 1,
  parameter int unsigned          LFSR_W    = 16,
  parameter logic [LFSR_BITS-1:0] SEED      = DEFAULT_SEED,
  parameter int unsigned          MAX_TRIES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [WIDTH-1:0]  value,
  output logic              valid,
  output logic              busy
);

  localparam int unsigned TRY_W = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VALUE);
  localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);

  // Elaboration-time parameter sanity checks.
  if (LFSR_W != LFSR_BITS) begin : g_err_lfsr_w
    $error("bounded_rng: LFSR_W must be 16");
  end
  if ((WIDTH < 1) || (WIDTH > LFSR_BITS)) begin : g_err_width
    $error("bounded_rng: WIDTH must be in 1..16");
  end
  if ((MAX_VALUE < 0) || (longint'(MAX_VALUE) > ((longint'(1) << WIDTH) - 1))) begin : g_err_max
    $error("bounded_rng: MAX_VALUE out of range for WIDTH");
  end
  if ((NO_REPEAT == 1) && (MAX_VALUE == 0)) begin : g_err_norep
    $error("bounded_rng: NO_REPEAT=1 needs MAX_VALUE > 0");
  end
  if (SEED == '0) begin : g_err_seed
    $error("bounded_rng: SEED must be non-zero");
  end
  if (MAX_TRIES < 1) begin : g_err_tries
    $error("bounded_rng: MAX_TRIES must be at least 1");
  end

  state_t             state_q, state_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [WIDTH-1:0]   last_q, last_d;
  logic               have_last_q, have_last_d;
  logic [WIDTH-1:0]   value_d;
  logic               valid_d, busy_d;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [WIDTH-1:0]   cand;
  logic [WIDTH:0]     last_inc;
  logic               cand_ok;
  logic [WIDTH-1:0]   fallback;
  logic               unused_lfsr;

  // Entropy source; its phase depends on when requests arrive.
  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_load),
    .load_val (seed_in),
    .q        (lfsr_q)
  );

  assign cand        = lfsr_q[WIDTH-1:0];
  assign unused_lfsr = ^lfsr_q;

  // Candidate acceptance and the wrap-around fallback, both at WIDTH+1 bits.
  always_comb begin
    last_inc = {1'b0, last_q} + (WIDTH+1)'(1);
    cand_ok  = ({1'b0, cand} <= MAX_EXT) &&
               ((NO_REPEAT == 0) || !have_last_q || (cand != last_q));
    if (!have_last_q || (last_inc > MAX_EXT)) begin
      fallback = '0;
    end else begin
      fallback = last_inc[WIDTH-1:0];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    tries_d     = tries_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    value_d     = value;
    valid_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = DRAW;
          tries_d = TRY_W'(1);
        end
      end
      DRAW: begin
        if (cand_ok) begin
          value_d     = cand;
          last_d      = cand;
          have_last_d = 1'b1;
          valid_d     = 1'b1;
          state_d     = IDLE;
        end else if (tries_q >= TRY_MAX) begin
          value_d     = fallback;
          last_d      = fallback;
          have_last_d = 1'b1;
          valid_d     = 1'b1;
          state_d     = IDLE;
        end else begin
          tries_d = tries_q + TRY_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tries_q     <= '0;
      last_q      <= '0;
      have_last_q <= 1'b0;
      value       <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      tries_q     <= tries_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      value       <= value_d;
      valid       <= valid_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_bounded_rng.sv
// Scoreboard bench for bounded_rng: four parameterisations share clk/rst_n.
module tb_bounded_rng;

  localparam int MX [4] = '{15, 9, 9, 15};
  localparam int NR [4] = '{1, 1, 0, 1};
  localparam int MT [4] = '{15, 15, 15, 1};

  typedef struct {
    int         inst;
    logic [3:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req [4];
  logic        seed_load [4];
  logic [15:0] seed_in [4];
  logic [3:0]  value [4];
  logic        valid [4];
  logic        busy [4];

  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  ml [4];
  bit          mh [4];
  logic [3:0]  p1, p2;
  bit          have_p1 = 0, have_p2 = 0;
  int          reps = 0;

  always #5 clk = ~clk;

  bounded_rng dut0 (.clk(clk), .rst_n(rst_n), .req(req[0]), .seed_load(seed_load[0]),
    .seed_in(seed_in[0]), .value(value[0]), .valid(valid[0]), .busy(busy[0]));
  bounded_rng #(.MAX_VALUE(9)) dut1 (.clk(clk), .rst_n(rst_n), .req(req[1]),
    .seed_load(seed_load[1]), .seed_in(seed_in[1]), .value(value[1]), .valid(valid[1]),
    .busy(busy[1]));
  bounded_rng #(.MAX_VALUE(9), .NO_REPEAT(0)) dut2 (.clk(clk), .rst_n(rst_n), .req(req[2]),
    .seed_load(seed_load[2]), .seed_in(seed_in[2]), .value(value[2]), .valid(valid[2]),
    .busy(busy[2]));
  bounded_rng #(.MAX_TRIES(1)) dut3 (.clk(clk), .rst_n(rst_n), .req(req[3]),
    .seed_load(seed_load[3]), .seed_in(seed_in[3]), .value(value[3]), .valid(valid[3]),
    .busy(busy[3]));

  function automatic logic [15:0] lnext(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] lfsr_of(input int i);
    case (i)
      0: return dut0.u_lfsr.q;
      1: return dut1.u_lfsr.q;
      2: return dut2.u_lfsr.q;
      default: return dut3.u_lfsr.q;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference draw: m is the LFSR value at the first attempt, left at the commit-edge value.
  task automatic model_draw(input int i, inout logic [15:0] m, output logic [3:0] v);
    logic [3:0] c;
    bit done;
    done = 0;
    v = 4'd0;
    for (int t = 1; t <= MT[i]; t++) begin
      c = m[3:0];
      m = lnext(m);
      if ((int'(c) <= MX[i]) && (NR[i] == 0 || !mh[i] || c != ml[i])) begin
        v = c;
        done = 1;
        break;
      end
    end
    if (!done) begin
      if (!mh[i] || (int'(ml[i]) + 1 > MX[i])) v = 4'd0;
      else v = ml[i] + 4'd1;
    end
    ml[i] = v;
    mh[i] = 1;
  endtask

  // Monitor: every valid pops the scoreboard.
  always @(negedge clk) begin
    exp_t ex;
    for (int i = 0; i < 4; i++) begin
      if (valid[i] === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(i + 1), 32'(0));
        end else begin
          ex = sb.pop_front();
          chk("sb_inst", 32'(i), 32'(ex.inst));
          chk("sb_value", 32'(value[i]), 32'(ex.val));
        end
        if (i == 1) begin
          chk("range_le_9", 32'(value[1] <= 4'd9), 32'(1));
          if (have_p1) chk("no_repeat", 32'(value[1] != p1), 32'(1));
          p1 = value[1];
          have_p1 = 1;
        end
        if (i == 2) begin
          if (have_p2 && value[2] == p2) reps++;
          p2 = value[2];
          have_p2 = 1;
        end
      end
    end
  end

  // Single directed draw with hand-computed value, latency and LFSR state.
  task automatic draw(input int i, input bit do_seed, input logic [15:0] s,
                      input logic [3:0] e, input int lat, input logic [15:0] lf);
    int n;
    if (do_seed) begin
      seed_in[i] = s;
      seed_load[i] = 1'b1;
      @(posedge clk); #1;
      seed_load[i] = 1'b0;
    end
    req[i] = 1'b1;
    sb.push_back(exp_t'{inst: i, val: e});
    @(posedge clk); #1;
    req[i] = 1'b0;
    chk("draw_busy", 32'(busy[i]), 32'(1));
    chk("draw_lfsr", 32'(lfsr_of(i)), 32'(lf));
    n = 0;
    while (valid[i] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("draw_latency", 32'(n), 32'(lat));
    chk("valid_busy_low", 32'(busy[i]), 32'(0));
    @(posedge clk); #1;
    chk("valid_one_cycle", 32'(valid[i]), 32'(0));
    ml[i] = e;
    mh[i] = 1;
  endtask

  // Seed, then hold req for n model-predicted draws.
  task automatic stream(input int i, input logic [15:0] s, input int n);
    logic [15:0] m;
    logic [3:0]  v;
    int cnt, cyc;
    bit pv;
    seed_in[i] = s;
    seed_load[i] = 1'b1;
    @(posedge clk); #1;
    seed_load[i] = 1'b0;
    m = (s != 16'h0) ? s : 16'hACE1;
    chk("seed_lfsr", 32'(lfsr_of(i)), 32'(m));
    m = lnext(m);
    for (int k = 0; k < n; k++) begin
      model_draw(i, m, v);
      sb.push_back(exp_t'{inst: i, val: v});
      m = lnext(m);
    end
    req[i] = 1'b1;
    cnt = 0;
    cyc = 0;
    pv = 0;
    while (cnt < n && cyc < n * 40) begin
      @(posedge clk); #1;
      cyc++;
      if (valid[i]) begin
        cnt++;
        chk("stream_busy_low", 32'(busy[i]), 32'(0));
        chk("stream_valid_gap", 32'(pv), 32'(0));
      end
      pv = valid[i];
    end
    req[i] = 1'b0;
    chk("stream_count", 32'(cnt), 32'(n));
    @(posedge clk); #1;
    chk("no_extra_draw", 32'(busy[i]), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      req[i] = 1'b0;
      seed_load[i] = 1'b0;
      seed_in[i] = 16'h0;
      ml[i] = 4'd0;
      mh[i] = 0;
    end
    #12;
    for (int i = 0; i < 4; i++) begin
      chk("rst_value", 32'(value[i]), 32'(0));
      chk("rst_valid", 32'(valid[i]), 32'(0));
      chk("rst_busy", 32'(busy[i]), 32'(0));
      chk("rst_lfsr", 32'(lfsr_of(i)), 32'(16'hACE1));
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Reset-phase draw: LFSR E270 in DRAW gives 0.
    draw(0, 0, 16'h0, 4'd0, 1, 16'hE270);
    // Reseed to ACE1: 0 repeats last and is rejected, 7138 gives 8.
    draw(0, 1, 16'hACE1, 4'd8, 2, 16'hE270);

    // MAX_TRIES=1 fallback: seed 000A yields cand 5, seed 001E yields cand 15.
    draw(3, 1, 16'h000A, 4'd5, 1, 16'h0005);
    draw(3, 1, 16'h000A, 4'd6, 1, 16'h0005);
    draw(3, 1, 16'h001E, 4'd15, 1, 16'h000F);
    draw(3, 1, 16'h001E, 4'd0, 1, 16'h000F);

    // Bounded range, with and without the no-repeat guarantee.
    stream(1, 16'h0E27, 1000);
    stream(2, 16'h0E27, 1000);

    // Held request, and a zero seed that must load ACE1.
    stream(0, 16'h0000, 8);

    // Reset mid-DRAW: asynchronous return, no valid, history cleared.
    draw(3, 1, 16'h000A, 4'd5, 1, 16'h0005);
    seed_in[3] = 16'h000A;
    seed_load[3] = 1'b1;
    @(posedge clk); #1;
    seed_load[3] = 1'b0;
    req[3] = 1'b1;
    @(posedge clk); #1;
    req[3] = 1'b0;
    chk("mid_draw_busy", 32'(busy[3]), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_value", 32'(value[3]), 32'(0));
    chk("async_busy", 32'(busy[3]), 32'(0));
    chk("async_valid", 32'(valid[3]), 32'(0));
    chk("async_lfsr", 32'(lfsr_of(3)), 32'(16'hACE1));
    for (int i = 0; i < 4; i++) begin
      ml[i] = 4'd0;
      mh[i] = 0;
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(valid[3]), 32'(0));
    draw(3, 1, 16'h000A, 4'd5, 1, 16'h0005);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'(0));
    chk("repeats_seen", 32'(reps > 0), 32'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
